tb_test_status_monitor: RTL and testbench
=========================================

// Module: tb_test_status_monitor
// PURPOSE
//  Testbench-side stage directly upstream of the DPI testbench hooks: snoops a simple write channel from the DUT
//  for tohost/heartbeat stores, tracks agent objections, and runs a cycle watchdog. Emits exactly one
//  finish_valid pulse with a 64-bit code; the hooks wrapper passes finish_code to dpi_test_finisher (0 = pass).
// PARAMETERS
//  ADDR_W          32            write address width
//  DATA_W          64            write data width (>= 2)
//  TOHOST_ADDR     'h0000_1000   tohost word address (exact match)
//  HEARTBEAT_ADDR  'h0000_1008   heartbeat address; any write restarts the watchdog
//  DRAIN_CYCLES    16            cycles waited after a finish request before the pulse
//  TIMEOUT_CYCLES  0             watchdog limit in RUN cycles; 0 disables the watchdog
//  TIMEOUT_CODE    64'hDEAD      finish_code reported on watchdog expiry
// PORTS
//  clock           in   1        single testbench clock
//  reset           in   1        synchronous, active-high reset
//  wr_valid        in   1        write beat valid
//  wr_ready        out  1        write beat accepted when wr_valid & wr_ready
//  wr_addr         in   ADDR_W   write address
//  wr_data         in   DATA_W   write data
//  obj_raise       in   1        agent raises one objection this cycle
//  obj_drop        in   1        agent drops one objection this cycle
//  finish_valid    out  1        one-cycle pulse: test is over
//  finish_code     out  64       0 = pass, nonzero = failure code; held stable from FIRE onward
//  timed_out       out  1        sticky: watchdog expired
//  obj_err         out  1        sticky: drop while count 0, or raise while count 255
// BEHAVIOUR
//  Reset (sync, any cycle incl. mid-drain): state=RUN, counters 0, wr_ready=0, finish_valid=0, finish_code=0,
//   timed_out=0, obj_err=0. Reset outputs visible the cycle after reset is sampled high.
//  wr_ready = (state==RUN), registered-free combinational from state. Non-matching addresses accepted, ignored.
//  States: RUN -> DRAIN -> FIRE -> DONE. DONE is absorbing until reset.
//  RUN: accepted tohost write with wr_data==0 is ignored. If wr_data[0]==1:
//   code = zero-extended wr_data[DATA_W-1:1] to 64b; is_fail = (code!=0). Load drain_cnt=DRAIN_CYCLES; go DRAIN.
//   wr_data[0]==0 and wr_data!=0: treated as failure, code = wr_data zero-extended (raw value).
//  Watchdog: wd_cnt increments each RUN cycle, clears on accepted heartbeat write. When TIMEOUT_CYCLES!=0 and
//   wd_cnt==TIMEOUT_CYCLES-1: code=TIMEOUT_CODE, is_fail=1, timed_out<=1, go DRAIN.
//   Same cycle tohost write accepted and expiry: tohost wins, timed_out stays 0.
//  Objections: 8-bit obj_cnt, updated in every state. raise&drop same cycle -> no change. Saturate at 255 / 0;
//   saturating attempt sets obj_err and leaves count unchanged.
//  DRAIN: if drain_cnt!=0, decrement. When drain_cnt==0 and (is_fail or obj_cnt==0) -> FIRE.
//   Pass waits indefinitely on objections; failure ignores them. Further writes are not accepted (wr_ready=0).
//  FIRE: finish_valid=1 for exactly this cycle; finish_code=code (registered on DRAIN entry). -> DONE.
//  Latency: tohost accepted at cycle N, no objections -> finish_valid at N+2+DRAIN_CYCLES.
//  DONE: finish_valid=0, finish_code held; inputs ignored except objection bookkeeping.
//  All arithmetic unsigned; wd_cnt width $clog2(TIMEOUT_CYCLES+1) (min 1), drain_cnt width $clog2(DRAIN_CYCLES+1).
// STRUCTURE
//  Package tb_status_pkg: state enum {RUN,DRAIN,FIRE,DONE}, PASS_CODE=64'h0, default TIMEOUT_CODE, OBJ_MAX=8'd255.
//  Sub-module tb_cycle_watchdog (clock, reset, enable, kick, limit param -> expire pulse) instantiated once.
//  Objection counter and FSM inline in this module.
// TESTING
//  1 Write tohost=1, DRAIN_CYCLES=16, no objections -> finish_valid single pulse at N+18, finish_code=0.
//  2 Write tohost=(5<<1)|1 with obj_cnt=2 -> pulse at N+18 regardless of objections, finish_code=5.
//  3 Pass write with 1 objection held; drop at N+40 -> FIRE at N+41 (obj_cnt 0 seen in DRAIN at N+41), code 0.
//  4 TIMEOUT_CYCLES=100, heartbeat at cycle 50, nothing else -> expiry at cycle 150ish exactly 100 RUN cycles
//   after kick, timed_out=1, finish_code=64'hDEAD; repeat with tohost on expiry cycle -> tohost code, timed_out=0.
//  5 obj_drop at count 0 -> obj_err=1, count stays 0; raise&drop together at count 3 -> stays 3.
//  6 Assert reset during DRAIN -> no finish_valid ever from that request; RUN, wr_ready=1 after release.

Source files
------------

// File: rtl/tb_status_pkg.sv
// Shared types and constants for the testbench status monitor: FSM state
// encoding, pass/timeout codes, objection limit and a counter-width helper.
package tb_status_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FIRE  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [63:0] PASS_CODE            = 64'h0;
    localparam logic [63:0] DEFAULT_TIMEOUT_CODE = 64'hDEAD;
    localparam logic [7:0]  OBJ_MAX              = 8'd255;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tb_cycle_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last kick and pulses expire
// when the count reaches LIMIT-1. LIMIT of 0 disables it entirely.
module tb_cycle_watchdog
    import tb_status_pkg::*;
#(
    parameter int LIMIT = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expire
);

    localparam int W = cnt_width(LIMIT);
    localparam logic [W-1:0] LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

    logic [W-1:0] wd_cnt;

    always_ff @(posedge clock) begin
        if (reset || kick) begin
            wd_cnt <= '0;
        end else if (enable && (LIMIT != 0)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A kick in the expiry cycle clears the counter but does not cancel the expiry.
    assign expire = (LIMIT != 0) && enable && (wd_cnt == LAST);

endmodule

// File: rtl/tb_test_status_monitor.sv
// Snoops the DUT write channel for tohost/heartbeat stores, tracks agent
// objections and the watchdog, and emits a single finish pulse with its code.
module tb_test_status_monitor
    import tb_status_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 'h0000_1000,
    parameter logic [ADDR_W-1:0] HEARTBEAT_ADDR = 'h0000_1008,
    parameter int                DRAIN_CYCLES   = 16,
    parameter int                TIMEOUT_CYCLES = 0,
    parameter logic [63:0]       TIMEOUT_CODE   = DEFAULT_TIMEOUT_CODE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              obj_raise,
    input  logic              obj_drop,
    output logic              finish_valid,
    output logic [63:0]       finish_code,
    output logic              timed_out,
    output logic              obj_err
);

    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_FIRE  = ST_FIRE;

    localparam int DW = cnt_width(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    logic [1:0]    state;
    logic [DW-1:0] drain_cnt;
    logic [7:0]    obj_cnt;
    logic          is_fail;
    logic [63:0]   code_q;
    logic          wr_fire;
    logic          tohost_hit;
    logic          hb_hit;
    logic          wd_expire;
    logic [63:0]   wr_code;

    // Handshake: a beat transfers on a cycle where wr_valid and wr_ready are both high;
    // wr_ready depends only on the state, never on wr_valid.
    assign wr_ready   = (state == S_RUN) && !reset;
    assign wr_fire    = wr_valid && wr_ready;
    assign tohost_hit = wr_fire && (wr_addr == TOHOST_ADDR) && (wr_data != '0);
    assign hb_hit     = wr_fire && (wr_addr == HEARTBEAT_ADDR);
    // Odd values carry a code in the upper bits; even nonzero values are raw failures.
    assign wr_code    = wr_data[0] ? 64'(wr_data >> 1) : 64'(wr_data);

    tb_cycle_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .enable (state == S_RUN),
        .kick   (hb_hit),
        .expire (wd_expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_RUN;
            drain_cnt <= '0;
            is_fail   <= 1'b0;
            code_q    <= PASS_CODE;
            timed_out <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (tohost_hit) begin
                        code_q    <= wr_code;
                        is_fail   <= (wr_code != PASS_CODE);
                        drain_cnt <= DRAIN_LOAD;
                        state     <= S_DRAIN;
                    end else if (wd_expire) begin
                        code_q    <= TIMEOUT_CODE;
                        is_fail   <= 1'b1;
                        timed_out <= 1'b1;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // A pass waits for every objection to drop; a failure does not.
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end else if (is_fail || (obj_cnt == 8'd0)) begin
                        state <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    state <= ST_DONE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            obj_cnt <= 8'd0;
            obj_err <= 1'b0;
        end else if (obj_raise && !obj_drop) begin
            if (obj_cnt == OBJ_MAX) obj_err <= 1'b1;
            else                    obj_cnt <= obj_cnt + 8'd1;
        end else if (obj_drop && !obj_raise) begin
            if (obj_cnt == 8'd0) obj_err <= 1'b1;
            else                 obj_cnt <= obj_cnt - 8'd1;
        end
    end

    assign finish_valid = (state == S_FIRE);
    assign finish_code  = code_q;

endmodule

// File: tb/tb_tb_test_status_monitor.sv
// Randomized and directed scenarios for tb_test_status_monitor, checked against
// a per-scenario arithmetic model of finish timing, code and sticky flags.
module tb_tb_test_status_monitor;

    localparam int          DRAIN  = 16;
    localparam int          TMO    = 100;
    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam logic [31:0] HB     = 32'h0000_1008;
    localparam int          MAXL   = 400;
    localparam int          LIM    = 1200;
    localparam int          EXP_W  = 97;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        obj_raise = 1'b0;
    logic        obj_drop = 1'b0;
    logic        wr_ready;
    logic        finish_valid;
    logic [63:0] finish_code;
    logic        timed_out;
    logic        obj_err;

    tb_test_status_monitor #(
        .ADDR_W         (32),
        .DATA_W         (64),
        .TOHOST_ADDR    (TOHOST),
        .HEARTBEAT_ADDR (HB),
        .DRAIN_CYCLES   (DRAIN),
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_CODE   (64'hDEAD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .obj_raise    (obj_raise),
        .obj_drop     (obj_drop),
        .finish_valid (finish_valid),
        .finish_code  (finish_code),
        .timed_out    (timed_out),
        .obj_err      (obj_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int edge_no = 0;
    always @(posedge clock) edge_no <= edge_no + 1;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] exp_item;

    logic        p_valid [MAXL];
    logic [31:0] p_addr  [MAXL];
    logic [63:0] p_data  [MAXL];
    logic        p_raise [MAXL];
    logic        p_drop  [MAXL];
    int          plan_len;
    int          cnt_before [LIM+1];
    logic        m_err;
    logic        m_tmo;
    logic [63:0] m_code;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        obj_raise = 1'b0;
        obj_drop  = 1'b0;
    endtask

    task automatic drive(input int i);
        wr_valid  = p_valid[i];
        wr_addr   = p_addr[i];
        wr_data   = p_data[i];
        obj_raise = p_raise[i];
        obj_drop  = p_drop[i];
    endtask

    task automatic clear_plan();
        for (int i = 0; i < MAXL; i++) begin
            p_valid[i] = 1'b0;
            p_addr[i]  = '0;
            p_data[i]  = '0;
            p_raise[i] = 1'b0;
            p_drop[i]  = 1'b0;
        end
        plan_len = 0;
    endtask

    task automatic put_write(input int i, input logic [31:0] a, input logic [63:0] d);
        p_valid[i] = 1'b1;
        p_addr[i]  = a;
        p_data[i]  = d;
        if (i + 1 > plan_len) plan_len = i + 1;
    endtask

    task automatic put_obj(input int i, input logic r, input logic d);
        p_raise[i] = r;
        p_drop[i]  = d;
        if (i + 1 > plan_len) plan_len = i + 1;
    endtask

    // ---------------- reference model ----------------
    // Index i of the plan is sampled on scenario edge i. Returns the edge
    // index where FIRE is entered (pulse seen after it), or -1 if never.
    task automatic compute_model(output int fire_rel);
        int   c;
        int   kick;
        int   ev;
        logic r;
        logic d;
        logic v;
        logic fail;
        c = 0;
        m_err = 1'b0;
        for (int i = 0; i <= LIM; i++) begin
            cnt_before[i] = c;
            r = (i < plan_len) ? p_raise[i] : 1'b0;
            d = (i < plan_len) ? p_drop[i]  : 1'b0;
            if (r && !d) begin
                if (c == 255) m_err = 1'b1; else c++;
            end else if (d && !r) begin
                if (c == 0) m_err = 1'b1; else c--;
            end
        end
        kick = -1;
        ev = -1;
        m_code = '0;
        m_tmo = 1'b0;
        for (int i = 0; i < LIM && ev < 0; i++) begin
            v = (i < plan_len) && p_valid[i];
            if (v && p_addr[i] == TOHOST && p_data[i] != 0) begin
                ev = i;
                m_code = p_data[i][0] ? (p_data[i] >> 1) : p_data[i];
                m_tmo = 1'b0;
            end else if (TMO != 0 && (i - kick - 1) == TMO - 1) begin
                ev = i;
                m_code = 64'hDEAD;
                m_tmo = 1'b1;
            end else if (v && p_addr[i] == HB) begin
                kick = i;
            end
        end
        fail = (m_code != 0);
        fire_rel = -1;
        if (ev >= 0) begin
            for (int f = ev + DRAIN + 1; f <= LIM && fire_rel < 0; f++) begin
                if (fail || cnt_before[f] == 0) fire_rel = f;
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (finish_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_finish_valid", 64'(finish_valid), 64'd0);
            end else begin
                exp_item = exp_q.pop_front();
                check("fire_edge", 64'(edge_no), 64'(exp_item[96:65]));
                check("finish_code", finish_code, exp_item[64:1]);
                check("timed_out_at_fire", 64'(timed_out), 64'(exp_item[0]));
            end
        end
    end

    // ---------------- scenario runner ----------------
    task automatic apply_reset(input string name);
        @(negedge clock);
        reset = 1'b1;
        idle();
        @(negedge clock);
        check({name, ":rst_finish_valid"}, 64'(finish_valid), 64'd0);
        check({name, ":rst_finish_code"}, finish_code, 64'd0);
        check({name, ":rst_timed_out"}, 64'(timed_out), 64'd0);
        check({name, ":rst_obj_err"}, 64'(obj_err), 64'd0);
        check({name, ":rst_wr_ready"}, 64'(wr_ready), 64'd0);
        reset = 1'b0;
        #1;
        check({name, ":run_wr_ready"}, 64'(wr_ready), 64'd1);
    endtask

    task automatic run_plan(input string name);
        int fire_rel;
        int start;
        int waited;
        apply_reset(name);
        compute_model(fire_rel);
        start = edge_no + 1;
        if (fire_rel >= 0) exp_q.push_back({32'(start + fire_rel), m_code, m_tmo});
        for (int i = 0; i < plan_len; i++) begin
            drive(i);
            @(negedge clock);
        end
        idle();
        waited = 0;
        while (exp_q.size() != 0 && waited < LIM + 50) begin
            @(negedge clock);
            waited++;
        end
        if (exp_q.size() != 0) begin
            check({name, ":pulse_wait_expired"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (3) @(negedge clock);
        check({name, ":held_finish_code"}, finish_code, m_code);
        check({name, ":timed_out"}, 64'(timed_out), 64'(m_tmo));
        check({name, ":obj_err"}, 64'(obj_err), 64'(m_err));
    endtask

    task automatic gen_random();
        int c;
        int sel;
        logic [63:0] d;
        c = 0;
        clear_plan();
        plan_len = $urandom_range(60, 120);
        for (int i = 0; i < plan_len; i++) begin
            if (i >= plan_len - 20) begin
                p_drop[i] = 1'b1;
            end else begin
                sel = $urandom_range(0, 15);
                if (sel < 2 && c < 15) begin
                    p_raise[i] = 1'b1;
                    c++;
                end else if (sel < 4) begin
                    p_drop[i] = 1'b1;
                    if (c > 0) c--;
                end else if (sel == 4) begin
                    p_raise[i] = 1'b1;
                    p_drop[i]  = 1'b1;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: d = 64'd0;
                    1: d = 64'd1;
                    2: d = ({$urandom, $urandom} << 1) | 64'd1;
                    default: d = {$urandom, $urandom};
                endcase
                sel = $urandom_range(0, 15);
                if (sel < 2)       put_write(i, TOHOST, d);
                else if (sel < 7)  put_write(i, HB, d);
                else if (sel < 10) put_write(i, TOHOST + 32'h4, d);
                else               put_write(i, $urandom, d);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle();
        repeat (2) @(negedge clock);

        clear_plan();
        put_write(5, TOHOST, 64'd1);
        run_plan("pass_no_obj");

        clear_plan();
        put_obj(0, 1'b1, 1'b0);
        put_obj(1, 1'b1, 1'b0);
        put_write(4, TOHOST, (64'd5 << 1) | 64'd1);
        put_obj(60, 1'b0, 1'b1);
        put_obj(61, 1'b0, 1'b1);
        run_plan("fail_with_obj");

        clear_plan();
        put_obj(0, 1'b1, 1'b0);
        put_write(2, TOHOST, 64'd1);
        put_obj(42, 1'b0, 1'b1);
        run_plan("pass_wait_obj");

        clear_plan();
        put_write(50, HB, 64'd0);
        run_plan("watchdog_expiry");

        clear_plan();
        put_write(50, HB, 64'd0);
        put_write(150, TOHOST, (64'd7 << 1) | 64'd1);
        run_plan("tohost_beats_expiry");

        clear_plan();
        put_obj(0, 1'b0, 1'b1);
        put_write(3, TOHOST, 64'd1);
        run_plan("drop_at_zero");

        clear_plan();
        for (int i = 0; i < 3; i++) put_obj(i, 1'b1, 1'b0);
        put_obj(3, 1'b1, 1'b1);
        put_write(4, TOHOST, 64'd1);
        for (int i = 30; i < 33; i++) put_obj(i, 1'b0, 1'b1);
        run_plan("raise_drop_same");

        clear_plan();
        for (int i = 0; i < 256; i++) put_obj(i, 1'b1, 1'b0);
        put_write(256, TOHOST, 64'h10);
        run_plan("raise_sat_raw_code");

        clear_plan();
        put_write(3, TOHOST + 32'h4, 64'd1);
        put_write(4, TOHOST, 64'd0);
        put_write(6, TOHOST, (64'd3 << 1) | 64'd1);
        run_plan("ignored_writes");

        // Reset during drain must cancel the pending finish.
        clear_plan();
        put_write(2, TOHOST, (64'd9 << 1) | 64'd1);
        apply_reset("mid_drain_pre");
        for (int i = 0; i < plan_len; i++) begin
            drive(i);
            @(negedge clock);
        end
        idle();
        repeat (5) @(negedge clock);
        check("mid_drain:wr_ready_in_drain", 64'(wr_ready), 64'd0);
        apply_reset("mid_drain");
        repeat (40) @(negedge clock);
        check("mid_drain:still_run", 64'(wr_ready), 64'd1);

        for (int k = 0; k < 8; k++) begin
            gen_random();
            run_plan($sformatf("random%0d", k));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
